// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, grant states,
// port indices and the misalignment rule used by both ports.
package dm_arbiter_pkg;

    typedef enum logic [2:0] {
        DM_W  = 3'd0,
        DM_H  = 3'd1,
        DM_B  = 3'd2,
        DM_HU = 3'd3,
        DM_BU = 3'd4
    } dm_sel_e;

    typedef enum logic {
        OWN_M   = 1'b0,
        FORCE_D = 1'b1
    } dm_state_e;

    localparam int NUM_PORTS = 2;
    localparam int PORT_M    = 0;
    localparam int PORT_D    = 1;

    // Misaligned size/offset pairs, undefined size codes and stores of an
    // unsigned size all count as a faulting access.
    function automatic logic dm_misaligned(logic [2:0] sel, logic we, logic [1:0] off);
        logic bad;
        case (sel)
            DM_W:        bad = (off != 2'b00);
            DM_H, DM_HU: bad = off[0];
            DM_B, DM_BU: bad = 1'b0;
            default:     bad = 1'b1;
        endcase
        if (we && (sel == DM_HU || sel == DM_BU)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU port, the DMA/debug port and the memory-side bus.
// slave is the arbiter's view; master is the surrounding pipeline/DMA/RAM.
interface dm_arbiter_if #(parameter int ADDR_W = 14);

    logic              m_req;
    logic              m_we;
    logic [2:0]        m_sel;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_stall;
    logic              m_err;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_sel;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  m_req, m_we, m_sel, m_addr, m_wdata,
        output m_rdata, m_stall, m_err,
        input  d_req, d_we, d_sel, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m_req, m_we, m_sel, m_addr, m_wdata,
        input  m_rdata, m_stall, m_err,
        output d_req, d_we, d_sel, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dm_lane.sv
// Per-port access shaping: byte enables, lane-replicated store data,
// extracted/extended load data and the fault flag. Purely combinational.
module dm_lane
    import dm_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  sel,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? raw[31:16] : raw[15:0];

    // Size decode; a faulting access never returns data.
    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata;
        rdata      = 32'h0;
        err        = dm_misaligned(sel, we, off);
        case (sel)
            DM_W: begin
                be    = 4'b1111;
                rdata = raw;
            end
            DM_H, DM_HU: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                rdata      = (sel == DM_H) ? {{16{half_sel[15]}}, half_sel}
                                           : {16'h0, half_sel};
            end
            DM_B, DM_BU: begin
                be         = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
                rdata      = (sel == DM_B) ? {{24{byte_sel[7]}}, byte_sel}
                                           : {24'h0, byte_sel};
            end
            default: ;
        endcase
        if (err) rdata = 32'h0;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the CPU M stage and a DMA/debug
// master. CPU normally owns the RAM; a D request denied MAX_WAIT times is
// forced through on the next cycle, stalling the CPU for that cycle.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    dm_state_e        state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             gnt_m, gnt_d, any_gnt;
    logic             d_rvalid_q, d_err_q;
    logic [31:0]      d_rdata_q;

    logic [NUM_PORTS-1:0]       p_we, l_err;
    logic [NUM_PORTS-1:0][2:0]  p_sel;
    logic [NUM_PORTS-1:0][1:0]  p_off;
    logic [NUM_PORTS-1:0][31:0] p_wdata, l_wdata, l_rdata;
    logic [NUM_PORTS-1:0][3:0]  l_be;

    assign p_we    = {bus.d_we, bus.m_we};
    assign p_sel   = {bus.d_sel, bus.m_sel};
    assign p_off   = {bus.d_addr[1:0], bus.m_addr[1:0]};
    assign p_wdata = {bus.d_wdata, bus.m_wdata};

    // Both lanes see the same raw word; only the granted one is meaningful.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
        dm_lane u_lane (
            .we         (p_we[p]),
            .sel        (p_sel[p]),
            .off        (p_off[p]),
            .wdata      (p_wdata[p]),
            .raw        (bus.mem_rdata),
            .be         (l_be[p]),
            .lane_wdata (l_wdata[p]),
            .rdata      (l_rdata[p]),
            .err        (l_err[p])
        );
    end

    // Grant decision and starvation tracking; reset holds every grant low.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        gnt_d        = reset & bus.d_req & ((state == FORCE_D) | ~bus.m_req);
        gnt_m        = reset & bus.m_req & ~gnt_d;
        if (gnt_d) begin
            wait_cnt_nxt = '0;
            state_nxt    = OWN_M;
        end else if (bus.d_req) begin
            if (wait_cnt != CNT_W'(MAX_WAIT)) wait_cnt_nxt = wait_cnt + CNT_W'(1);
            if (wait_cnt_nxt == CNT_W'(MAX_WAIT)) state_nxt = FORCE_D;
        end else begin
            state_nxt = OWN_M;
        end
    end

    // Grant state and denial counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= OWN_M;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign any_gnt = gnt_m | gnt_d;

    // Memory bus driven by whichever port holds the grant.
    assign bus.mem_we    = any_gnt & p_we[gnt_d] & ~l_err[gnt_d];
    assign bus.mem_be    = any_gnt ? l_be[gnt_d] : 4'b0000;
    assign bus.mem_wdata = l_wdata[gnt_d];
    assign bus.mem_addr  = gnt_d ? bus.d_addr[ADDR_W-1:0] : bus.m_addr[ADDR_W-1:0];

    // CPU side answers in the same cycle.
    assign bus.m_rdata = gnt_m ? l_rdata[PORT_M] : 32'h0;
    assign bus.m_err   = gnt_m & l_err[PORT_M];
    assign bus.m_stall = bus.m_req & gnt_d;
    assign bus.d_gnt   = gnt_d;

    // DMA response captured on grant, presented one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_err_q    <= 1'b0;
        end else begin
            d_rvalid_q <= gnt_d;
            if (gnt_d) begin
                d_rdata_q <= l_rdata[PORT_D];
                d_err_q   <= l_err[PORT_D];
            end
        end
    end

    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.m_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed and random checks of dm_arbiter against a byte-level memory model
// and a "denied count" view of the arbitration rule.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 4;
    localparam int NBYTES   = 1 << ADDR_W;
    localparam int NWORDS   = NBYTES / 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    dm_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    // RAM the DUT talks to (word array, async read).
    logic [31:0] dmem [NWORDS];
    assign bus.mem_rdata = dmem[bus.mem_addr[ADDR_W-1:2]];

    function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] be, logic [31:0] nw);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk)
        if (bus.mem_we) dmem[bus.mem_addr[ADDR_W-1:2]] <= merge(dmem[bus.mem_addr[ADDR_W-1:2]], bus.mem_be, bus.mem_wdata);

    // Reference state.
    logic [7:0]  ref_mem [NBYTES];
    int          denied;
    bit          exp_rv, exp_re, last_gd;
    logic [31:0] exp_rd;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(logic [2:0] sel);
        case (sel)
            3'd0:       return 4;
            3'd1, 3'd3: return 2;
            3'd2, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    // Reference view of one access from the byte memory.
    task automatic model_access(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                                input logic [31:0] wdata, output bit err, output logic [3:0] be,
                                output logic [31:0] wrep, output logic [31:0] rdata);
        int size, off, a;
        int unsigned v;
        size = size_of(sel);
        off  = int'(addr % 4);
        a    = int'(addr % NBYTES);
        err  = (size == 0) || (int'(addr % size) != 0) || (we && (sel == 3'd3 || sel == 3'd4));
        be   = (size == 0) ? 4'b0 : 4'(((1 << size) - 1) << off);
        case (size)
            2:       wrep = (wdata & 32'hFFFF) * 32'h0001_0001;
            1:       wrep = (wdata & 32'hFF) * 32'h0101_0101;
            default: wrep = wdata;
        endcase
        v = 0;
        for (int i = 0; i < size; i++) v = v + (int'(ref_mem[(a + i) % NBYTES]) << (8 * i));
        if (sel == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        if (sel == 3'd2 && v >= 128)   v = v + 32'hFFFF_FF00;
        rdata = err ? 32'h0 : v;
    endtask

    task automatic model_write(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] wdata);
        int a;
        a = int'(addr % NBYTES);
        for (int i = 0; i < size_of(sel); i++) ref_mem[(a + i) % NBYTES] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic setm(logic req, logic we, logic [2:0] sel, logic [31:0] addr, logic [31:0] wd);
        bus.m_req = req; bus.m_we = we; bus.m_sel = sel; bus.m_addr = addr; bus.m_wdata = wd;
    endtask

    task automatic setd(logic req, logic we, logic [2:0] sel, logic [31:0] addr, logic [31:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_sel = sel; bus.d_addr = addr; bus.d_wdata = wd;
    endtask

    // One clock: check combinational outputs, step model, check D response.
    // Entered 1-2 time units after a rising edge with inputs already driven.
    task automatic cycle(string tag);
        bit          force_d, gd, gm, merr, derr, ewe, gw;
        logic [3:0]  mbe, dbe, ebe;
        logic [31:0] mwr, dwr, mrd, drd, ewr, eaddr;
        logic [2:0]  gsel;
        #1;
        force_d = bus.d_req && denied >= MAX_WAIT;
        gd = bus.d_req && (!bus.m_req || force_d);
        gm = bus.m_req && !gd;
        model_access(bus.m_we, bus.m_sel, bus.m_addr, bus.m_wdata, merr, mbe, mwr, mrd);
        model_access(bus.d_we, bus.d_sel, bus.d_addr, bus.d_wdata, derr, dbe, dwr, drd);
        gw    = gd ? bus.d_we : bus.m_we;
        gsel  = gd ? bus.d_sel : bus.m_sel;
        ewe   = (gm || gd) && gw && !(gd ? derr : merr);
        ebe   = gd ? dbe : mbe;
        ewr   = gd ? dwr : mwr;
        eaddr = (gd ? bus.d_addr : bus.m_addr) % NBYTES;
        chk({tag, ".d_gnt"},   32'(bus.d_gnt),   32'(gd));
        chk({tag, ".m_stall"}, 32'(bus.m_stall), 32'(bus.m_req && gd));
        chk({tag, ".m_err"},   32'(bus.m_err),   32'(gm && merr));
        chk({tag, ".m_rdata"}, bus.m_rdata,      gm ? mrd : 32'h0);
        chk({tag, ".mem_we"},  32'(bus.mem_we),  32'(ewe));
        if (ewe) begin
            chk({tag, ".mem_be"},    32'(bus.mem_be),   32'(ebe));
            chk({tag, ".mem_wdata"}, bus.mem_wdata,     ewr);
            chk({tag, ".mem_addr"},  32'(bus.mem_addr), eaddr);
        end
        @(posedge clk);
        if (ewe) model_write(gsel, gd ? bus.d_addr : bus.m_addr, gd ? bus.d_wdata : bus.m_wdata);
        if (gd) denied = 0;
        else if (bus.d_req && denied < MAX_WAIT) denied++;
        exp_rv = gd; exp_rd = drd; exp_re = derr; last_gd = gd;
        #1;
        chk({tag, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(exp_rv));
        if (exp_rv) begin
            chk({tag, ".d_rdata"}, bus.d_rdata,     exp_rd);
            chk({tag, ".d_err"},   32'(bus.d_err),  32'(exp_re));
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
        return a;
    endfunction

    function automatic logic [2:0] rnd_sel();
        if ($urandom_range(0, 9) == 0) return 3'($urandom_range(5, 7));
        return 3'($urandom_range(0, 4));
    endfunction

    initial begin
        bit d_pend;
        for (int i = 0; i < NWORDS; i++) dmem[i] = 32'h0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h0;
        denied = 0; exp_rv = 0; exp_re = 0; exp_rd = 0; last_gd = 0;
        setm(0, 0, DM_W, 0, 0);
        setd(0, 0, DM_W, 0, 0);

        // Reset state, including a D request that must not be granted.
        #1;
        chk("rst.d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("rst.m_stall",  32'(bus.m_stall),  32'h0);
        chk("rst.mem_we",   32'(bus.mem_we),   32'h0);
        setd(1, 0, DM_W, 32'h10, 0);
        setm(1, 1, DM_W, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("rst.d_gnt",  32'(bus.d_gnt),  32'h0);
        chk("rst.mem_we2", 32'(bus.mem_we), 32'h0);
        setd(0, 0, DM_W, 0, 0);
        setm(0, 0, DM_W, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // M store W then M load B of the top byte.
        setm(1, 1, DM_W, 32'h10, 32'h1234_5678);
        #1; chk("st_w.be", 32'(bus.mem_be), 32'hF);
        cycle("st_w");
        setm(1, 0, DM_B, 32'h13, 0);
        #1; chk("ld_b.rdata", bus.m_rdata, 32'h0000_0012);
        chk("ld_b.stall", 32'(bus.m_stall), 32'h0);
        cycle("ld_b");

        // Halfword store to the upper half, then signed and unsigned loads.
        setm(1, 1, DM_H, 32'h22, 32'hFFFF_8001);
        #1; chk("st_h.be", 32'(bus.mem_be), 32'hC);
        chk("st_h.wdata", bus.mem_wdata, 32'h8001_8001);
        cycle("st_h");
        setm(1, 0, DM_H, 32'h22, 0);
        #1; chk("ld_h.rdata", bus.m_rdata, 32'hFFFF_8001);
        cycle("ld_h");
        setm(1, 0, DM_HU, 32'h22, 0);
        #1; chk("ld_hu.rdata", bus.m_rdata, 32'h0000_8001);
        cycle("ld_hu");

        // Idle CPU: D granted immediately, response next cycle.
        setm(0, 0, DM_W, 0, 0);
        setd(1, 0, DM_W, 32'h10, 0);
        #1; chk("d_ld.gnt", 32'(bus.d_gnt), 32'h1);
        cycle("d_ld");
        chk("d_ld.rdata", bus.d_rdata, 32'h1234_5678);
        setd(0, 0, DM_W, 0, 0);

        // Misaligned M store is dropped; misaligned D load errors.
        setm(1, 1, DM_W, 32'h11, 32'hAAAA_AAAA);
        #1; chk("st_mis.err", 32'(bus.m_err), 32'h1);
        cycle("st_mis");
        setm(1, 0, DM_W, 32'h10, 0);
        #1; chk("st_mis.keep", bus.m_rdata, 32'h1234_5678);
        cycle("st_mis_rd");
        setm(0, 0, DM_W, 0, 0);
        setd(1, 0, DM_H, 32'h01, 0);
        cycle("d_mis");
        chk("d_mis.err", 32'(bus.d_err), 32'h1);
        chk("d_mis.rdata", bus.d_rdata, 32'h0);

        // Starvation: D forced through after MAX_WAIT denials.
        setd(1, 0, DM_W, 32'h20, 0);
        for (int k = 0; k < 7; k++) begin
            setm(1, 0, DM_W, 32'h10, 0);
            if (k == 5) setd(0, 0, DM_W, 0, 0);
            #1;
            chk("starve.gnt",   32'(bus.d_gnt),   32'(k == MAX_WAIT));
            chk("starve.stall", 32'(bus.m_stall), 32'(k == MAX_WAIT));
            cycle("starve");
        end

        // Asynchronous reset while a D response is being presented.
        setm(0, 0, DM_W, 0, 0);
        setd(1, 0, DM_W, 32'h10, 0);
        cycle("pre_rst");
        #1; reset = 1'b0;
        #1;
        chk("async.d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("async.d_rdata",  bus.d_rdata,       32'h0);
        chk("async.d_gnt",    32'(bus.d_gnt),    32'h0);
        chk("async.mem_we",   32'(bus.mem_we),   32'h0);
        denied = 0; exp_rv = 0;
        setd(0, 0, DM_W, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        cycle("post_rst");

        // Random traffic; D holds its request until granted.
        d_pend = 0;
        for (int n = 0; n < 400; n++) begin
            setm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_sel(), rnd_addr(), $urandom);
            if (!d_pend) begin
                if ($urandom_range(0, 2) == 0)
                    setd(1, 1'($urandom_range(0, 1)), rnd_sel(), rnd_addr(), $urandom);
                else
                    setd(0, 0, DM_W, 0, 0);
            end
            cycle("rnd");
            d_pend = bus.d_req && !last_gd;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
